// File: rtl/mc_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | mc_ctrl_pkg: shared types and encodings for the multicycle control   |
// | unit (states, opcodes, funct codes, ALU codes, mux select codes).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL,
        S_JR, S_TRAP
    } state_t;

    // What the FSM asks of the ALU; ACLS_FUNCT defers to the R-type funct field.
    typedef enum logic [2:0] {
        ACLS_ADD, ACLS_SUB, ACLS_AND, ACLS_SLT, ACLS_FUNCT
    } alu_cls_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;
    localparam logic [5:0] c_FN_JR  = 6'b001000;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam logic [1:0] c_SRCB_B      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] c_RDST_RT = 2'b00;
    localparam logic [1:0] c_RDST_RD = 2'b01;
    localparam logic [1:0] c_RDST_RA = 2'b10;

    localparam logic [1:0] c_M2R_ALUOUT = 2'b00;
    localparam logic [1:0] c_M2R_MDR    = 2'b01;
    localparam logic [1:0] c_M2R_PC     = 2'b10;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] c_PCSRC_REG    = 2'b11;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// +----------------------------------------------------------------------+
// | alu_ctrl_decode: maps the FSM's ALU request class and funct field    |
// | to an ALU control code; flags unsupported R-type funct values.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTL_W = 3
) (
    input  alu_cls_t              alu_cls_i,
    input  logic [5:0]            funct_i,
    output logic [ALU_CTL_W-1:0]  alu_ctl_o,
    output logic                  illegal_o
);

    logic [2:0] w_code;

    always_comb begin
        w_code    = c_ALU_ADD;
        illegal_o = 1'b0;
        case (alu_cls_i)
            ACLS_ADD: w_code = c_ALU_ADD;
            ACLS_SUB: w_code = c_ALU_SUB;
            ACLS_AND: w_code = c_ALU_AND;
            ACLS_SLT: w_code = c_ALU_SLT;
            ACLS_FUNCT: begin
                case (funct_i)
                    c_FN_ADD: w_code = c_ALU_ADD;
                    c_FN_SUB: w_code = c_ALU_SUB;
                    c_FN_AND: w_code = c_ALU_AND;
                    c_FN_OR:  w_code = c_ALU_OR;
                    c_FN_SLT: w_code = c_ALU_SLT;
                    default:  illegal_o = 1'b1;
                endcase
            end
            default: w_code = c_ALU_ADD;
        endcase
    end

    assign alu_ctl_o = ALU_CTL_W'(w_code);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_unit.sv
// +----------------------------------------------------------------------+
// | multicycle_ctrl_unit: main FSM + ALU control for the multicycle MIPS |
// | core with stalling memory, timeout/illegal trap. CTRL_PERF_CNT_EN    |
// | adds cycle/instruction counters. Revision: 1.0                       |
// +----------------------------------------------------------------------+
`default_nettype none

module multicycle_ctrl_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTL_W   = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_CNT_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTL_W-1:0]  alu_ctl,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  i_or_d,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            reg_dst,
    output logic [1:0]            mem_to_reg,
    output logic                  pc_write,
    output logic                  pc_write_cond_beq,
    output logic                  pc_write_cond_bne,
    output logic [1:0]            pc_src,
    output logic                  trap,
    output logic                  trap_cause
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           instr_cnt
`endif
);

    state_t                 state_q, state_d;
    logic [TMO_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                   trap_cause_q, trap_cause_d;

    alu_cls_t               w_alu_cls;
    logic                   w_illegal;
    logic                   w_waiting;
    logic                   w_timeout;
    logic                   w_unused_zero;

    // The branch condition is resolved in the datapath from the cond enables.
    assign w_unused_zero = zero;

    assign w_waiting  = is_wait_state(state_q) && !mem_ready;
    assign w_timeout  = w_waiting && (wait_cnt_q == TMO_CNT_W'(MEM_TIMEOUT - 1));
    assign wait_cnt_d = w_waiting ? (wait_cnt_q + TMO_CNT_W'(1)) : '0;

    always_comb begin
        w_alu_cls = ACLS_ADD;
        case (state_q)
            S_R_EXEC: w_alu_cls = ACLS_FUNCT;
            S_BRANCH: w_alu_cls = ACLS_SUB;
            S_I_EXEC: begin
                if (opcode == c_OP_SLTI)      w_alu_cls = ACLS_SLT;
                else if (opcode == c_OP_ANDI) w_alu_cls = ACLS_AND;
                else                          w_alu_cls = ACLS_ADD;
            end
            default:  w_alu_cls = ACLS_ADD;
        endcase
    end

    alu_ctrl_decode #(
        .ALU_CTL_W (ALU_CTL_W)
    ) u_alu_ctrl_decode (
        .alu_cls_i (w_alu_cls),
        .funct_i   (funct),
        .alu_ctl_o (alu_ctl),
        .illegal_o (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= '0;
            trap_cause_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        trap_cause_d      = trap_cause_q;
        alu_src_a         = 1'b0;
        alu_src_b         = c_SRCB_B;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        i_or_d            = 1'b0;
        ir_write          = 1'b0;
        reg_write         = 1'b0;
        reg_dst           = c_RDST_RT;
        mem_to_reg        = c_M2R_ALUOUT;
        pc_write          = 1'b0;
        pc_write_cond_beq = 1'b0;
        pc_write_cond_bne = 1'b0;
        pc_src            = c_PCSRC_ALU;

        if (!rst) begin
            state_d      = S_FETCH;
            trap_cause_d = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = c_SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end else if (w_timeout) begin
                        state_d      = S_TRAP;
                        trap_cause_d = 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_src_b = c_SRCB_IMM_SH;
                    case (opcode)
                        c_OP_RTYPE: state_d = (funct == c_FN_JR) ? S_JR : S_R_EXEC;
                        c_OP_LW, c_OP_SW:                   state_d = S_MEM_ADDR;
                        c_OP_BEQ, c_OP_BNE:                 state_d = S_BRANCH;
                        c_OP_J:                             state_d = S_JUMP;
                        c_OP_JAL:                           state_d = S_JAL;
                        c_OP_ADDI, c_OP_SLTI, c_OP_ANDI:    state_d = S_I_EXEC;
                        default: begin
                            state_d      = S_TRAP;
                            trap_cause_d = 1'b0;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = c_SRCB_IMM;
                    state_d   = (opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end else if (w_timeout) begin
                        state_d      = S_TRAP;
                        trap_cause_d = 1'b1;
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = c_RDST_RT;
                    mem_to_reg = c_M2R_MDR;
                    state_d    = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end else if (w_timeout) begin
                        state_d      = S_TRAP;
                        trap_cause_d = 1'b1;
                    end
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = c_SRCB_B;
                    if (w_illegal) begin
                        state_d      = S_TRAP;
                        trap_cause_d = 1'b0;
                    end else begin
                        state_d = S_R_WB;
                    end
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = c_RDST_RD;
                    mem_to_reg = c_M2R_ALUOUT;
                    state_d    = S_FETCH;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = c_SRCB_IMM;
                    state_d   = S_I_WB;
                end
                S_I_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = c_RDST_RT;
                    mem_to_reg = c_M2R_ALUOUT;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a         = 1'b1;
                    alu_src_b         = c_SRCB_B;
                    pc_src            = c_PCSRC_ALUOUT;
                    pc_write_cond_beq = (opcode == c_OP_BEQ);
                    pc_write_cond_bne = (opcode == c_OP_BNE);
                    state_d           = S_FETCH;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = c_PCSRC_JUMP;
                    state_d  = S_FETCH;
                end
                S_JAL: begin
                    // PC already holds PC+4 here, so it is the link value.
                    pc_write   = 1'b1;
                    pc_src     = c_PCSRC_JUMP;
                    reg_write  = 1'b1;
                    reg_dst    = c_RDST_RA;
                    mem_to_reg = c_M2R_PC;
                    state_d    = S_FETCH;
                end
                S_JR: begin
                    pc_write = 1'b1;
                    pc_src   = c_PCSRC_REG;
                    state_d  = S_FETCH;
                end
                S_TRAP: state_d = S_TRAP;
                default: begin
                    state_d      = S_TRAP;
                    trap_cause_d = 1'b0;
                end
            endcase
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = trap_cause_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instr_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_TRAP) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_unit.sv
// +----------------------------------------------------------------------+
// | tb_multicycle_ctrl_unit: scoreboard bench for multicycle_ctrl_unit.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_ctrl_unit;

    localparam int T_FETCH = 0,  T_DECODE = 1, T_MADDR = 2, T_MRD = 3,
                   T_MWB   = 4,  T_MWR    = 5, T_REXEC = 6, T_RWB = 7,
                   T_IEXEC = 8,  T_IWB    = 9, T_BR    = 10, T_J = 11,
                   T_JAL   = 12, T_JR     = 13, T_TRAP = 14,
                   T_QUIET = 15, T_RSTA   = 16;

    typedef struct packed {
        logic       a;
        logic [1:0] b;
        logic [2:0] alu;
        logic       mr, mw, iod, irw, rw;
        logic [1:0] rd, m2r;
        logic       pcw, beq, bne;
        logic [1:0] pcs;
        logic       trap, cause;
    } outs_t;

    typedef struct {
        string tag;
        outs_t e;
        outs_t m;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       alu_src_a, mem_read, mem_write, i_or_d, ir_write, reg_write;
    logic [1:0] alu_src_b, reg_dst, mem_to_reg, pc_src;
    logic [2:0] alu_ctl;
    logic       pc_write, pc_write_cond_beq, pc_write_cond_bne, trap, trap_cause;

    int  n_checks = 0;
    int  n_errors = 0;
    sb_t sb[$];

    multicycle_ctrl_unit #(
        .ALU_CTL_W   (3),
        .MEM_TIMEOUT (16),
        .TMO_CNT_W   (5)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .opcode            (opcode),
        .funct             (funct),
        .zero              (zero),
        .mem_ready         (mem_ready),
        .alu_src_a         (alu_src_a),
        .alu_src_b         (alu_src_b),
        .alu_ctl           (alu_ctl),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .i_or_d            (i_or_d),
        .ir_write          (ir_write),
        .reg_write         (reg_write),
        .reg_dst           (reg_dst),
        .mem_to_reg        (mem_to_reg),
        .pc_write          (pc_write),
        .pc_write_cond_beq (pc_write_cond_beq),
        .pc_write_cond_bne (pc_write_cond_bne),
        .pc_src            (pc_src),
        .trap              (trap),
        .trap_cause        (trap_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outputs per state, with a care mask for the fields each state defines.
    task automatic expect_state(input int st, input logic rdy, input logic [2:0] alu,
                                input logic flag, output outs_t e, output outs_t m);
        e = '0;
        m = '0;
        m.mr = 1; m.mw = 1; m.irw = 1; m.rw = 1; m.pcw = 1; m.beq = 1; m.bne = 1;
        m.trap = 1; m.cause = 1;
        case (st)
            T_FETCH: begin
                e.mr = 1; e.irw = rdy; e.pcw = rdy; e.b = 2'b01; e.alu = 3'b010;
                m.a = 1; m.b = 2'b11; m.alu = 3'b111; m.iod = 1; m.pcs = 2'b11;
            end
            T_DECODE: begin
                e.b = 2'b11; e.alu = 3'b010;
                m.a = 1; m.b = 2'b11; m.alu = 3'b111;
            end
            T_MADDR: begin
                e.a = 1; e.b = 2'b10; e.alu = 3'b010;
                m.a = 1; m.b = 2'b11; m.alu = 3'b111;
            end
            T_MRD:   begin e.mr = 1; e.iod = 1; m.iod = 1; end
            T_MWB:   begin e.rw = 1; e.rd = 2'b00; e.m2r = 2'b01; m.rd = 2'b11; m.m2r = 2'b11; end
            T_MWR:   begin e.mw = 1; e.iod = 1; m.iod = 1; end
            T_REXEC, T_IEXEC: begin
                e.a = 1; e.b = (st == T_REXEC) ? 2'b00 : 2'b10; e.alu = alu;
                m.a = 1; m.b = 2'b11; m.alu = 3'b111;
            end
            T_RWB:   begin e.rw = 1; e.rd = 2'b01; e.m2r = 2'b00; m.rd = 2'b11; m.m2r = 2'b11; end
            T_IWB:   begin e.rw = 1; e.rd = 2'b00; e.m2r = 2'b00; m.rd = 2'b11; m.m2r = 2'b11; end
            T_BR: begin
                e.a = 1; e.b = 2'b00; e.alu = 3'b110; e.pcs = 2'b01;
                e.beq = !flag; e.bne = flag;
                m.a = 1; m.b = 2'b11; m.alu = 3'b111; m.pcs = 2'b11;
            end
            T_J:     begin e.pcw = 1; e.pcs = 2'b10; m.pcs = 2'b11; end
            T_JAL: begin
                e.pcw = 1; e.pcs = 2'b10; e.rw = 1; e.rd = 2'b10; e.m2r = 2'b10;
                m.pcs = 2'b11; m.rd = 2'b11; m.m2r = 2'b11;
            end
            T_JR:    begin e.pcw = 1; e.pcs = 2'b11; m.pcs = 2'b11; end
            T_TRAP:  begin e.trap = 1; e.cause = flag; end
            T_RSTA:  begin m.trap = 0; m.cause = 0; end
            default: begin end
        endcase
    endtask

    task automatic run(input string tag, input logic rs, input logic [5:0] op,
                       input logic [5:0] fn, input logic rdy, input logic z,
                       input int st, input logic [2:0] alu, input logic flag);
        sb_t it;
        @(posedge clk);
        #1;
        rst = rs; opcode = op; funct = fn; mem_ready = rdy; zero = z;
        it.tag = tag;
        expect_state(st, rdy, alu, flag, it.e, it.m);
        sb.push_back(it);
    endtask

    task automatic go(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input int st, input logic [2:0] alu, input logic flag);
        run(tag, 1'b1, op, fn, rdy, 1'b0, st, alu, flag);
    endtask

    task automatic do_reset();
        run("rst_a", 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, T_RSTA, 3'b0, 1'b0);
        run("rst_b", 1'b0, 6'h00, 6'h00, 1'b1, 1'b0, T_QUIET, 3'b0, 1'b0);
    endtask

    task automatic rtype(input string tag, input logic [5:0] fn, input logic [2:0] alu);
        go({tag, "_f"}, 6'h00, fn, 1'b1, T_FETCH, 3'b0, 1'b0);
        go({tag, "_d"}, 6'h00, fn, 1'b0, T_DECODE, 3'b0, 1'b0);
        go({tag, "_x"}, 6'h00, fn, 1'b0, T_REXEC, alu, 1'b0);
        go({tag, "_w"}, 6'h00, fn, 1'b0, T_RWB, 3'b0, 1'b0);
    endtask

    task automatic itype(input string tag, input logic [5:0] op, input logic [2:0] alu);
        go({tag, "_f"}, op, 6'h15, 1'b1, T_FETCH, 3'b0, 1'b0);
        go({tag, "_d"}, op, 6'h15, 1'b0, T_DECODE, 3'b0, 1'b0);
        go({tag, "_x"}, op, 6'h15, 1'b0, T_IEXEC, alu, 1'b0);
        go({tag, "_w"}, op, 6'h15, 1'b0, T_IWB, 3'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t   it;
            outs_t g;
            it = sb.pop_front();
            g = {alu_src_a, alu_src_b, alu_ctl, mem_read, mem_write, i_or_d, ir_write,
                 reg_write, reg_dst, mem_to_reg, pc_write, pc_write_cond_beq,
                 pc_write_cond_bne, pc_src, trap, trap_cause};
            chk(it.tag, 32'(g & it.m), 32'(it.e & it.m));
        end
    end

    initial begin
        do_reset();

        rtype("add", 6'b100000, 3'b010);
        rtype("sub", 6'b100010, 3'b110);
        rtype("and", 6'b100100, 3'b000);
        rtype("or",  6'b100101, 3'b001);
        rtype("slt", 6'b101010, 3'b111);

        itype("addi", 6'b001000, 3'b010);
        itype("slti", 6'b001010, 3'b111);
        itype("andi", 6'b001100, 3'b000);

        // lw with three stalled cycles in MEM_RD
        go("lw_f", 6'b100011, 6'h00, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("lw_d", 6'b100011, 6'h00, 1'b0, T_DECODE, 3'b0, 1'b0);
        go("lw_a", 6'b100011, 6'h00, 1'b0, T_MADDR, 3'b0, 1'b0);
        for (int i = 0; i < 3; i++) go("lw_stall", 6'b100011, 6'h00, 1'b0, T_MRD, 3'b0, 1'b0);
        go("lw_rd", 6'b100011, 6'h00, 1'b1, T_MRD, 3'b0, 1'b0);
        go("lw_wb", 6'b100011, 6'h00, 1'b0, T_MWB, 3'b0, 1'b0);

        go("sw_f", 6'b101011, 6'h00, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("sw_d", 6'b101011, 6'h00, 1'b0, T_DECODE, 3'b0, 1'b0);
        go("sw_a", 6'b101011, 6'h00, 1'b0, T_MADDR, 3'b0, 1'b0);
        go("sw_wr", 6'b101011, 6'h00, 1'b1, T_MWR, 3'b0, 1'b0);

        go("beq_f", 6'b000100, 6'h00, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("beq_d", 6'b000100, 6'h00, 1'b0, T_DECODE, 3'b0, 1'b0);
        run("beq_b", 1'b1, 6'b000100, 6'h00, 1'b0, 1'b1, T_BR, 3'b0, 1'b0);
        go("bne_f", 6'b000101, 6'h00, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("bne_d", 6'b000101, 6'h00, 1'b0, T_DECODE, 3'b0, 1'b0);
        run("bne_b", 1'b1, 6'b000101, 6'h00, 1'b0, 1'b1, T_BR, 3'b0, 1'b1);

        go("j_f", 6'b000010, 6'h00, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("j_d", 6'b000010, 6'h00, 1'b0, T_DECODE, 3'b0, 1'b0);
        go("j_j", 6'b000010, 6'h00, 1'b0, T_J, 3'b0, 1'b0);
        go("jal_f", 6'b000011, 6'h00, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("jal_d", 6'b000011, 6'h00, 1'b0, T_DECODE, 3'b0, 1'b0);
        go("jal_j", 6'b000011, 6'h00, 1'b0, T_JAL, 3'b0, 1'b0);
        go("jr_f", 6'b000000, 6'b001000, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("jr_d", 6'b000000, 6'b001000, 1'b0, T_DECODE, 3'b0, 1'b0);
        go("jr_j", 6'b000000, 6'b001000, 1'b0, T_JR, 3'b0, 1'b0);

        // Ready on the last allowed wait cycle completes the fetch
        for (int i = 0; i < 15; i++) go("fetch_wait", 6'h00, 6'b100000, 1'b0, T_FETCH, 3'b0, 1'b0);
        go("fetch_late", 6'h00, 6'b100000, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("late_d", 6'h00, 6'b100000, 1'b0, T_DECODE, 3'b0, 1'b0);
        go("late_x", 6'h00, 6'b100000, 1'b0, T_REXEC, 3'b010, 1'b0);
        go("late_w", 6'h00, 6'b100000, 1'b0, T_RWB, 3'b0, 1'b0);

        // Illegal opcode: trap, sticky against inputs, recover after reset
        go("ill_f", 6'b111111, 6'h00, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("ill_d", 6'b111111, 6'h00, 1'b1, T_DECODE, 3'b0, 1'b0);
        for (int i = 0; i < 3; i++) go("ill_trap", 6'(i), 6'b100000, 1'b1, T_TRAP, 3'b0, 1'b0);
        do_reset();
        rtype("rec", 6'b100000, 3'b010);

        // Illegal funct traps from R_EXEC without entering R_WB
        go("fn_f", 6'h00, 6'b111111, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("fn_d", 6'h00, 6'b111111, 1'b0, T_DECODE, 3'b0, 1'b0);
        go("fn_x", 6'h00, 6'b111111, 1'b0, T_QUIET, 3'b0, 1'b0);
        go("fn_trap", 6'h00, 6'b111111, 1'b1, T_TRAP, 3'b0, 1'b0);
        go("fn_trap2", 6'h00, 6'b100000, 1'b1, T_TRAP, 3'b0, 1'b0);
        do_reset();

        // Fetch timeout: 16 wait cycles, then trap with cause 1
        for (int i = 0; i < 16; i++) go("tmo_wait", 6'h00, 6'h00, 1'b0, T_FETCH, 3'b0, 1'b0);
        go("tmo_trap", 6'h00, 6'h00, 1'b0, T_TRAP, 3'b0, 1'b1);
        go("tmo_trap2", 6'h00, 6'h00, 1'b1, T_TRAP, 3'b0, 1'b1);
        do_reset();

        // Read timeout in MEM_RD
        go("rtmo_f", 6'b100011, 6'h00, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("rtmo_d", 6'b100011, 6'h00, 1'b0, T_DECODE, 3'b0, 1'b0);
        go("rtmo_a", 6'b100011, 6'h00, 1'b0, T_MADDR, 3'b0, 1'b0);
        for (int i = 0; i < 16; i++) go("rtmo_wait", 6'b100011, 6'h00, 1'b0, T_MRD, 3'b0, 1'b0);
        go("rtmo_trap", 6'b100011, 6'h00, 1'b0, T_TRAP, 3'b0, 1'b1);
        do_reset();

        // Reset in the middle of a stalled store
        go("mid_f", 6'b101011, 6'h00, 1'b1, T_FETCH, 3'b0, 1'b0);
        go("mid_d", 6'b101011, 6'h00, 1'b0, T_DECODE, 3'b0, 1'b0);
        go("mid_a", 6'b101011, 6'h00, 1'b0, T_MADDR, 3'b0, 1'b0);
        go("mid_w", 6'b101011, 6'h00, 1'b0, T_MWR, 3'b0, 1'b0);
        go("mid_w2", 6'b101011, 6'h00, 1'b0, T_MWR, 3'b0, 1'b0);
        do_reset();
        go("mid_rec", 6'b101011, 6'h00, 1'b0, T_FETCH, 3'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl_unit.md
Name: multicycle_ctrl_unit

Overview:
- Parametrised next-generation control unit for the multicycle MIPS core. Drives the datapath's mux selects, enables and ALU control.
- Merges the main FSM and the ALU-control decode.
- Adds stall-capable memory (mem_ready handshake with timeout), the jal/jr/addi/slti/andi instructions, and a sticky trap state for illegal opcodes and bus timeouts.

Parameters:
- ALU_CTL_W, 3, width of alu_ctl output.
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready before trap (≥1).
- TMO_CNT_W, 5, width of the wait counter (must hold MEM_TIMEOUT).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=sext imm, 11=sext imm<<2
- alu_ctl  out  ALU_CTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
- mem_read, mem_write  out  1 each
- i_or_d  out  1  0=PC address, 1=ALUOut address
- ir_write  out  1
- reg_write  out  1
- reg_dst  out  2  00=rt, 01=rd, 10=$31
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC
- pc_write, pc_write_cond_beq, pc_write_cond_bne  out  1 each
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr)
- trap  out  1  sticky: illegal opcode/funct or memory timeout
- trap_cause  out  1  0=illegal, 1=timeout

Behaviour:
- Reset (rst==0 at clk edge): state=FETCH, wait counter=0, trap=0, trap_cause=0. All enables are 0 while rst is low.
- States:
  - FETCH
  - DECODE
  - MEM_ADDR
  - MEM_RD
  - MEM_WB
  - MEM_WR
  - R_EXEC
  - R_WB
  - I_EXEC
  - I_WB
  - BRANCH
  - JUMP
  - JAL
  - JR
  - TRAP
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctl=add, pc_src=00.
  - ir_write and pc_write equal mem_ready (Mealy), so PC+4 and IR load in the same cycle.
  - Stays in FETCH until mem_ready, then moves to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctl=add (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC, or JR when funct=001000
  - 100011/101011 → MEM_ADDR
  - 000100/000101 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - 001000/001010/001100 → I_EXEC
  - anything else → TRAP with cause 0
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctl from funct:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt
  - any other funct → TRAP with cause 0; R_WB is not entered
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00. Then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_ctl = add (addi), slt (slti) or and (andi). Then I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01. pc_write_cond_beq or pc_write_cond_bne is asserted per opcode. Then FETCH.
- JUMP: pc_write=1, pc_src=10. Then FETCH.
- JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. The PC already holds PC+4 at this point. Then FETCH.
- JR: pc_write=1, pc_src=11. Then FETCH.
- Wait counter:
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on leaving those states.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP, trap_cause=1.
  - If mem_ready arrives in the same cycle the count reaches MEM_TIMEOUT, the access completes and there is no trap.
- TRAP: all enables 0, trap=1. Held until reset; inputs are ignored.
- Reset mid-stall or mid-instruction: returns to FETCH with no write enables asserted in the reset cycle.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined, adds two outputs:
  - cycle_cnt[31:0]: increments every non-reset cycle except in TRAP.
  - instr_cnt[31:0]: increments on every transition into FETCH from a non-FETCH state.
  - Both clear on reset and wrap modulo 2^32.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum
  - opcode and funct localparams
  - alu_ctl codes
  - alu_src_b / reg_dst / mem_to_reg / pc_src select codes
- Sub-module alu_ctrl_decode: combinational; inputs are the state class and funct, outputs alu_ctl and an illegal flag. It is instantiated once.

Test Plan:
- Reset then opcode=000000, funct=100000, mem_ready=1 → FETCH, DECODE, R_EXEC (alu_ctl=010), R_WB (reg_write=1, reg_dst=01), FETCH. 4 cycles per instruction.
- lw with mem_ready low for 3 cycles in MEM_RD → mem_read held 4 cycles, then MEM_WB with mem_to_reg=01. No trap.
- beq with zero=1 → in BRANCH, pc_write_cond_beq=1, pc_src=01, alu_ctl=110. For bne, only pc_write_cond_bne=1.
- jal → JAL state with pc_write=1, reg_dst=10, mem_to_reg=10. jr (funct=001000) → pc_src=11.
- opcode=111111 → TRAP after DECODE, trap=1, trap_cause=0. Stays there until rst=0; it recovers afterwards.
- mem_ready stuck 0 in FETCH → trap asserts after exactly MEM_TIMEOUT=16 wait cycles, trap_cause=1. With mem_ready=1 on cycle 16 → no trap.
